// File: rtl/sd_decimator.sv
// Sigma-delta decimator: first-order 1-bit modulator front end with an
// external RC integrator. The comparator output is synchronized and
// re-registered as the feedback bit. That feedback bit is counted over a
// window of 2^C_OSR_LOG2 clocks to form one sample, which is handed over
// through a valid/ack handshake with a sticky overrun flag.
`timescale 1ns/1ps

module sd_decimator #(
   parameter int C_CLK_FRQ      = 100_000_000,
   parameter int C_SAMPLE_WIDTH = 8,
   parameter int C_OSR_LOG2     = 8
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic                      enable,
   input  logic                      sdIn,
   output logic                      sdFb,
   output logic                      valid,
   input  logic                      ack,
   output logic [C_SAMPLE_WIDTH-1:0] data,
   output logic                      error
);

   localparam int C_SHIFT = C_OSR_LOG2 - C_SAMPLE_WIDTH;
   localparam logic [C_OSR_LOG2-1:0] C_CNT_MAX  = {C_OSR_LOG2{1'b1}};
   localparam logic [C_OSR_LOG2-1:0] C_CNT_ZERO = {C_OSR_LOG2{1'b0}};
   localparam logic [C_OSR_LOG2-1:0] C_CNT_ONE  = C_OSR_LOG2'(1'b1);
   localparam logic [C_OSR_LOG2:0]   C_ACC_ZERO = {(C_OSR_LOG2+1){1'b0}};

   // Elaboration-time guard on the parameter set; the clock frequency only
   // has to be meaningful, it does not shape any logic.
   if ((C_OSR_LOG2 < C_SAMPLE_WIDTH) || (C_SAMPLE_WIDTH < 1) || (C_CLK_FRQ <= 0)) begin : gBadParam
      $error("sd_decimator: illegal parameters (need C_OSR_LOG2 >= C_SAMPLE_WIDTH >= 1, C_CLK_FRQ > 0)");
   end

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                    state_r;
   state_t                    stateNext_s;
   logic                      sync1_r;
   logic                      sync2_r;
   logic                      sdFb_r;
   logic [C_OSR_LOG2-1:0]     cnt_r;
   logic [C_OSR_LOG2-1:0]     cntNext_s;
   logic [C_OSR_LOG2:0]       acc_r;
   logic [C_OSR_LOG2:0]       accNext_s;
   logic [C_OSR_LOG2:0]       total_s;
   logic                      winDone_s;
   logic [C_SAMPLE_WIDTH-1:0] sample_s;
   logic [C_SAMPLE_WIDTH-1:0] data_r;
   logic [C_SAMPLE_WIDTH-1:0] dataNext_s;
   logic                      valid_r;
   logic                      validNext_s;
   logic                      error_r;
   logic                      errorNext_s;

   // Scale a full-window ones count to the sample width. A window of all
   // ones counts to 2^C_OSR_LOG2, which does not fit and is clamped.
   function automatic logic [C_SAMPLE_WIDTH-1:0] scaleSample(input logic [C_OSR_LOG2:0] total);
      logic [C_OSR_LOG2:0] shifted;
      shifted = total >> C_SHIFT;
      if (total[C_OSR_LOG2]) begin
         return {C_SAMPLE_WIDTH{1'b1}};
      end else begin
         return shifted[C_SAMPLE_WIDTH-1:0];
      end
   endfunction

   assign total_s  = acc_r + {C_CNT_ZERO, sdFb_r};
   assign sample_s = scaleSample(total_s);

   // Two-flop synchronizer for the comparator; the third flop is the feedback bit.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sdFb_r  <= 1'b0;
      end else begin
         sync1_r <= sdIn;
         sync2_r <= sync1_r;
         sdFb_r  <= sync2_r;
      end
   end

   // Window sequencing: IDLE holds the count clear, RUN accumulates the feedback bit.
   always_comb begin
      stateNext_s = state_r;
      cntNext_s   = cnt_r;
      accNext_s   = acc_r;
      winDone_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (enable) begin
               // The enabling edge is already the first window clock.
               stateNext_s = RUN;
               cntNext_s   = cnt_r + C_CNT_ONE;
               accNext_s   = total_s;
            end else begin
               cntNext_s   = C_CNT_ZERO;
               accNext_s   = C_ACC_ZERO;
            end
         end
         RUN: begin
            if (!enable) begin
               // Partial window is thrown away.
               stateNext_s = IDLE;
               cntNext_s   = C_CNT_ZERO;
               accNext_s   = C_ACC_ZERO;
            end else if (cnt_r == C_CNT_MAX) begin
               winDone_s   = 1'b1;
               cntNext_s   = C_CNT_ZERO;
               accNext_s   = C_ACC_ZERO;
            end else begin
               cntNext_s   = cnt_r + C_CNT_ONE;
               accNext_s   = total_s;
            end
         end
         default: begin
            stateNext_s = IDLE;
            cntNext_s   = C_CNT_ZERO;
            accNext_s   = C_ACC_ZERO;
         end
      endcase
   end

   // Sample handover: load when the slot is free or freed on this edge, else flag overrun.
   always_comb begin
      dataNext_s  = data_r;
      validNext_s = valid_r;
      errorNext_s = error_r;
      if (winDone_s) begin
         if (!valid_r || ack) begin
            dataNext_s  = sample_s;
            validNext_s = 1'b1;
            errorNext_s = 1'b0;
         end else begin
            errorNext_s = 1'b1;
         end
      end else if (valid_r && ack) begin
         validNext_s = 1'b0;
         errorNext_s = 1'b0;
      end else begin
         dataNext_s  = data_r;
         validNext_s = valid_r;
         errorNext_s = error_r;
      end
   end

   // State, window counter and accumulator registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_r <= IDLE;
         cnt_r   <= C_CNT_ZERO;
         acc_r   <= C_ACC_ZERO;
      end else begin
         state_r <= stateNext_s;
         cnt_r   <= cntNext_s;
         acc_r   <= accNext_s;
      end
   end

   // Output sample, valid and sticky overrun registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         data_r  <= {C_SAMPLE_WIDTH{1'b0}};
         valid_r <= 1'b0;
         error_r <= 1'b0;
      end else begin
         data_r  <= dataNext_s;
         valid_r <= validNext_s;
         error_r <= errorNext_s;
      end
   end

   assign sdFb  = sdFb_r;
   assign valid = valid_r;
   assign data  = data_r;
   assign error = error_r;

endmodule

// File: tb/tb_sd_decimator.sv
// Bench for sd_decimator: a small behavioural model of the feedback
// pipeline and window counting pushes expected samples into a scoreboard
// queue; samples are popped and compared when the DUT raises valid.
`timescale 1ns/1ps

module tb_sd_decimator;

   localparam int W   = 8;
   localparam int N   = 8;
   localparam int WIN = 1 << N;

   logic         clk = 1'b0;
   logic         rstb;
   logic         enable;
   logic         sdIn;
   logic         ack;
   logic         sdFb;
   logic         valid;
   logic [W-1:0] data;
   logic         error;

   sd_decimator #(
      .C_CLK_FRQ      (100_000_000),
      .C_SAMPLE_WIDTH (W),
      .C_OSR_LOG2     (N)
   ) dut (
      .clk    (clk),
      .rstb   (rstb),
      .enable (enable),
      .sdIn   (sdIn),
      .sdFb   (sdFb),
      .valid  (valid),
      .ack    (ack),
      .data   (data),
      .error  (error)
   );

   always #5 clk = ~clk;

   int           testsRun    = 0;
   int           testsFailed = 0;
   // model state
   logic         mS1, mS2, mFb;
   int           mCnt, mAcc;
   logic [W-1:0] sbQ[$];
   int           cycle       = 0;
   logic         ackReq      = 1'b0;
   bit           autoAck     = 1'b0;
   int           lastValidCyc = -1;
   int           pat         = 0;
   logic [W-1:0] expA, expB;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   function automatic logic [W-1:0] expSample(input int total);
      int s;
      s = total >> (N - W);
      if (total >= WIN) return {W{1'b1}};
      else return s[W-1:0];
   endfunction

   function automatic logic patBit();
      case (pat)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return cycle[0];
         3:       return 1'($urandom_range(0, 1));
         default: return 1'b0;
      endcase
   endfunction

   task automatic modelReset();
      mS1 = 1'b0; mS2 = 1'b0; mFb = 1'b0;
      mCnt = 0; mAcc = 0;
      sbQ.delete();
   endtask

   task automatic popExp(input string tag, output logic [W-1:0] e);
      checkVal({tag, "_sbAvail"}, 32'(sbQ.size() > 0), 32'd1);
      if (sbQ.size() > 0) e = sbQ.pop_front();
      else e = {W{1'b0}};
   endtask

   task automatic consume();
      logic [W-1:0] e;
      popExp("auto", e);
      checkVal("autoData", 32'(data), 32'(e));
      checkVal("autoErr", 32'(error), 32'd0);
      if (lastValidCyc >= 0) checkVal("period", 32'(cycle - lastValidCyc), 32'(WIN));
      lastValidCyc = cycle;
      ackReq = 1'b1;
   endtask

   // one clock: drive at negedge, model the edge, observe at next negedge
   task automatic tick(input logic en);
      logic b;
      b = patBit();
      sdIn = b; enable = en; ack = ackReq;
      @(posedge clk);
      cycle++;
      if (en) begin
         if (mCnt == WIN - 1) begin
            sbQ.push_back(expSample(mAcc + int'(mFb)));
            mAcc = 0; mCnt = 0;
         end else begin
            mAcc += int'(mFb); mCnt++;
         end
      end else begin
         mAcc = 0; mCnt = 0;
      end
      mFb = mS2; mS2 = mS1; mS1 = b;
      @(negedge clk);
      ackReq = 1'b0;
      if (autoAck && valid === 1'b1) consume();
   endtask

   task automatic runUntilValid(input string tag);
      for (int i = 0; i < WIN + 4; i++) begin
         if (valid === 1'b1) break;
         tick(1'b1);
      end
      checkVal(tag, 32'(valid), 32'd1);
   endtask

   task automatic runUntilCnt(input int target);
      for (int i = 0; i < WIN + 2; i++) begin
         if (mCnt == target) break;
         tick(1'b1);
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstb = 1'b0; enable = 1'b0; sdIn = 1'b0; ack = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkVal("rstValid", 32'(valid), 32'd0);
      checkVal("rstData",  32'(data),  32'd0);
      checkVal("rstErr",   32'(error), 32'd0);
      checkVal("rstFb",    32'(sdFb),  32'd0);
      rstb = 1'b1;

      // idle after reset, then feedback latency
      pat = 0;
      repeat (5) tick(1'b0);
      checkVal("idleValid", 32'(valid), 32'd0);
      pat = 1;
      tick(1'b0); checkVal("latRise1", 32'(sdFb), 32'd0);
      tick(1'b0); checkVal("latRise2", 32'(sdFb), 32'd0);
      tick(1'b0); checkVal("latRise3", 32'(sdFb), 32'd1);
      pat = 0;
      tick(1'b0); checkVal("latFall1", 32'(sdFb), 32'd1);
      tick(1'b0); checkVal("latFall2", 32'(sdFb), 32'd1);
      tick(1'b0); checkVal("latFall3", 32'(sdFb), 32'd0);

      // streaming with ack on every sample
      autoAck = 1'b1; lastValidCyc = -1;
      pat = 1; repeat (3 * WIN) tick(1'b1);
      checkVal("satData", 32'(data), 32'hFF);
      pat = 0; repeat (3 * WIN) tick(1'b1);
      checkVal("zeroData", 32'(data), 32'h00);
      pat = 2; repeat (3 * WIN) tick(1'b1);
      checkVal("togData", 32'(data), 32'h80);
      autoAck = 1'b0;
      tick(1'b1);                     // pending ack lands here

      // overrun: two completions without ack
      pat = 3;
      runUntilValid("ovrFirst");
      popExp("ovr1", expA);
      checkVal("ovrData1", 32'(data), 32'(expA));
      runUntilCnt(WIN - 1); tick(1'b1);
      checkVal("ovrValid", 32'(valid), 32'd1);
      checkVal("ovrErr",   32'(error), 32'd1);
      checkVal("ovrHeld",  32'(data),  32'(expA));
      if (sbQ.size() > 0) void'(sbQ.pop_front());
      ackReq = 1'b1; tick(1'b1);
      checkVal("ackValid", 32'(valid), 32'd0);
      checkVal("ackErr",   32'(error), 32'd0);
      checkVal("ackData",  32'(data),  32'(expA));

      // overrun, then window completion on the same edge as ack
      runUntilValid("sameFirst");
      popExp("same1", expA);
      checkVal("sameData1", 32'(data), 32'(expA));
      runUntilCnt(WIN - 1); tick(1'b1);
      checkVal("sameErrSet", 32'(error), 32'd1);
      if (sbQ.size() > 0) void'(sbQ.pop_front());
      runUntilCnt(WIN - 1);
      ackReq = 1'b1; tick(1'b1);
      popExp("same2", expB);
      checkVal("sameValid", 32'(valid), 32'd1);
      checkVal("sameErr",   32'(error), 32'd0);
      checkVal("sameData",  32'(data),  32'(expB));
      ackReq = 1'b1; tick(1'b1);
      checkVal("sameAckValid", 32'(valid), 32'd0);

      // abort window at clock 100, then re-enable
      runUntilCnt(100);
      repeat (10) tick(1'b0);
      checkVal("abortValid", 32'(valid), 32'd0);
      checkVal("abortData",  32'(data),  32'(expB));
      checkVal("abortSb",    32'(sbQ.size()), 32'd0);
      repeat (WIN - 1) tick(1'b1);
      checkVal("reenEarly", 32'(valid), 32'd0);
      checkVal("reenHold",  32'(data),  32'(expB));
      tick(1'b1);
      checkVal("reenValid", 32'(valid), 32'd1);
      popExp("reen", expA);
      checkVal("reenData", 32'(data), 32'(expA));

      // reset mid-window with valid and error set
      runUntilCnt(WIN - 1); tick(1'b1);
      if (sbQ.size() > 0) void'(sbQ.pop_front());
      pat = 1;
      runUntilCnt(150);
      checkVal("preValid", 32'(valid), 32'd1);
      checkVal("preErr",   32'(error), 32'd1);
      checkVal("preFb",    32'(sdFb),  32'd1);
      #2 rstb = 1'b0;
      #1;
      checkVal("asyncValid", 32'(valid), 32'd0);
      checkVal("asyncData",  32'(data),  32'd0);
      checkVal("asyncErr",   32'(error), 32'd0);
      checkVal("asyncFb",    32'(sdFb),  32'd0);
      @(negedge clk); @(negedge clk);
      rstb = 1'b1;
      modelReset();
      repeat (5) tick(1'b0);
      checkVal("postRstIdle", 32'(valid), 32'd0);
      repeat (WIN - 1) tick(1'b1);
      checkVal("postRstEarly", 32'(valid), 32'd0);
      tick(1'b1);
      checkVal("postRstValid", 32'(valid), 32'd1);
      popExp("postRst", expA);
      checkVal("postRstData", 32'(data), 32'(expA));
      checkVal("postRstSat",  32'(data), 32'hFF);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/sd_decimator.md
SD_DECIMATOR -- requirements
Module: sd_decimator

Interface
REQ-001 The block SHALL have parameter C_CLK_FRQ, default 100_000_000, meaning system clock frequency [Hz], used for documentation and assertion only.
REQ-002 The block SHALL have parameter C_SAMPLE_WIDTH, default 8, meaning output sample width [bit].
REQ-003 The block SHALL have parameter C_OSR_LOG2, default 8, meaning log2 of the oversampling ratio; legal range is C_OSR_LOG2 >= C_SAMPLE_WIDTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rstb, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: conversion run control, high = convert.
REQ-007 The block SHALL have port sdIn, input, 1 bit: asynchronous comparator output of the external RC integrator.
REQ-008 The block SHALL have port sdFb, output, 1 bit: registered 1-bit feedback that drives the external RC integrator.
REQ-009 The block SHALL have port valid, output, 1 bit: high when data holds an unacknowledged sample.
REQ-010 The block SHALL have port ack, input, 1 bit: consumer acknowledge of the current sample.
REQ-011 The block SHALL have port data, output, C_SAMPLE_WIDTH bits: last decimated sample.
REQ-012 The block SHALL have port error, output, 1 bit: sticky overrun flag.

Function
REQ-013 sdIn SHALL pass through a 2-flop synchronizer; sdFb SHALL be a third register fed by the synchronizer output, and sdFb is the bit that is counted.
REQ-014 The FSM SHALL have two states: IDLE (enable low) and RUN (enable high).
REQ-015 In IDLE, the window counter (C_OSR_LOG2 bits) and the ones accumulator (C_OSR_LOG2+1 bits) SHALL be held at 0; sdFb SHALL keep toggling per sdIn.
REQ-016 IDLE->RUN SHALL occur on the first edge with enable=1; the window SHALL start on that edge, with counter 0 and the first accumulated bit.
REQ-017 RUN->IDLE SHALL occur on the first edge with enable=0; the partial window SHALL be discarded, and valid/data/error SHALL be held.
REQ-018 In RUN, on each edge the accumulator SHALL add sdFb and the window counter SHALL increment, wrapping from 2^C_OSR_LOG2-1 to 0.
REQ-019 On the edge where the counter equals 2^C_OSR_LOG2-1, the block SHALL form total = acc + sdFb.
REQ-020 On that same edge, data SHALL be loaded with total >> (C_OSR_LOG2-C_SAMPLE_WIDTH), saturated to all-ones when total = 2^C_OSR_LOG2.
REQ-021 On that same edge, the accumulator SHALL be cleared and valid SHALL be set; the sample period is exactly 2^C_OSR_LOG2 clocks.
REQ-022 An edge with valid=1 and ack=1 SHALL clear valid and error on that edge; ack with valid=0 SHALL be ignored.
REQ-023 If a window completes while valid=1 and ack=0, data SHALL NOT be overwritten, valid SHALL stay 1, and error SHALL be set.
REQ-024 If a window completes on the same edge as ack with valid=1, the new sample SHALL load, valid SHALL stay 1, and error SHALL clear.
REQ-025 Latency SHALL be 3 clocks from an sdIn change to the corresponding sdFb change.
REQ-026 A change on sdIn SHALL affect the count no earlier than 3 clocks after it occurs.

Reset
REQ-027 rstb=0 SHALL immediately (asynchronously) force valid=0, data=0, error=0, sdFb=0, synchronizer flops=0, counter=0, accumulator=0 and state=IDLE, including mid-window.
REQ-028 After rstb rises, the block SHALL remain in IDLE until the first edge with enable=1.

Verification (defaults: C_SAMPLE_WIDTH=8, C_OSR_LOG2=8)
REQ-029 sdIn=1 constant, enable=1, ack pulsed on each valid -> valid every 256 clocks, data=0xFF (saturated from 256), error=0.
REQ-030 sdIn=0 constant -> data=0x00 every 256 clocks; sdIn toggling every clock -> data=0x80 (±1 at window alignment).
REQ-031 ack held 0 across two window completions -> first sample retained, valid=1, error=1 after the second completion; one ack cycle -> valid=0, error=0.
REQ-032 Window completion on the same edge as ack -> valid stays 1, data updates, error=0.
REQ-033 enable dropped at window clock 100, then raised -> no valid from the aborted window; next valid exactly 256 clocks after the re-enable edge; prior data unchanged meanwhile.
REQ-034 rstb pulsed low at window clock 150 with valid=1 and error=1 -> all outputs 0 asynchronously; no valid until 256 clocks after the first enable=1 edge following release.
